uart_tx_arbiter: RTL and testbench

- Shares the single byte-wide UART transmit stream between NUM_PORTS AXI-Stream sources, for example processor output bytes and a status/debug byte source.
- Arbitrates packet-atomically with round-robin fairness: a grant is held from the first beat until the tlast beat.
- A stall watchdog releases the grant if the owning source stops presenting data mid-packet, so one stuck source cannot hang the UART link.
- Sits between the stream adapters and the uart transmitter input.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART transmit stream between NUM_PORTS
// AXI-Stream sources. A grant lasts from the first beat to the tlast beat, and
// round-robin ordering keeps the sources fair. A stall watchdog forces a release
// when the owning source stops presenting data in the middle of a packet.
module uart_tx_arbiter #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic                            grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_idx,
  output logic                            timeout
);

  localparam int unsigned IdxW   = $clog2(NUM_PORTS);
  localparam bit          WdogEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CntW   = WdogEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_idx_q, grant_idx_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic            timeout_q, timeout_d;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;

  // Round-robin search: first requesting port after last_grant, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = IdxW'((32'(last_grant_q) + k) % NUM_PORTS);
      if (!pick_found && s_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic: arbitration, packet completion and stall watchdog.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    stall_cnt_d  = stall_cnt_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall_cnt_d = '0;
        if (pick_found) begin
          state_d      = StLocked;
          grant_idx_d  = pick_idx;
          last_grant_d = pick_idx;
        end
      end
      StLocked: begin
        if (s_tvalid[grant_idx_q] && m_tready) begin
          // A completed transfer always beats the watchdog.
          stall_cnt_d = '0;
          if (s_tlast[grant_idx_q]) begin
            state_d = StIdle;
          end
        end else if (!s_tvalid[grant_idx_q] && WdogEn) begin
          if (stall_cnt_q != CntMax) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
          // Release without a synthesised tlast; the downstream packet is truncated.
          if (stall_cnt_d == CntMax) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset gives port 0 first priority.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= StIdle;
      grant_idx_q  <= '0;
      last_grant_q <= IdxW'(NUM_PORTS - 1);
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      stall_cnt_q  <= stall_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Zero-latency data path: the owning port is muxed straight through.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == StLocked) begin
      m_tdata               = s_tdata[32'(grant_idx_q) * DATA_WIDTH +: DATA_WIDTH];
      m_tvalid              = s_tvalid[grant_idx_q];
      m_tlast               = s_tlast[grant_idx_q];
      s_tready[grant_idx_q] = m_tready;
    end
  end

  assign grant_valid = (state_q == StLocked);
  assign grant_idx   = grant_idx_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-port source queues drive the DUT, a scoreboard
// holds each port's issued beats, and a monitor checks every cycle against a
// behavioural model of ownership, round-robin order and the stall watchdog.
module tb_uart_tx_arbiter;

  localparam int NP = 2;
  localparam int DW = 8;
  localparam int TO = 4;

  logic                 clk = 1'b0;
  logic                 arst;
  logic [NP*DW-1:0]     s_tdata;
  logic [NP-1:0]        s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]        m_tdata;
  logic                 m_tvalid, m_tlast, m_tready;
  logic                 grant_valid;
  logic [$clog2(NP)-1:0] grant_idx;
  logic                 timeout;

  uart_tx_arbiter #(
    .NUM_PORTS     (NP),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            hold;  // idle cycles before the source presents this beat
  } beat_t;

  beat_t src_q[NP][$];
  beat_t exp_q[NP][$];
  beat_t cur[NP];
  bit    cur_act[NP];
  int    cur_hold[NP];
  bit    acc[NP];
  bit    rdy_pat[$];
  bit    rdy_rand;

  int n_vec, n_err;
  int grant_log[$];
  int n_to;
  bit gv_prev;

  // Reference model: who owns the output, who was granted last, stall run length.
  int m_owner, m_last, m_stall;
  bit m_tout;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = NP - 1;
    m_stall = 0;
    m_tout  = 0;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare DUT against the model each cycle, then advance the model.
  always @(negedge clk) begin : monitor
    bit            exp_gv, exp_mv, found;
    logic [NP-1:0] exp_rdy;
    beat_t         e;
    int            c;
    if (arst) model_reset();
    exp_gv = (m_owner >= 0);
    exp_mv = 1'b0;
    if (exp_gv) exp_mv = s_tvalid[m_owner];
    exp_rdy = '0;
    if (exp_gv) exp_rdy[m_owner] = m_tready;
    chk("grant_valid", grant_valid, exp_gv);
    if (exp_gv) chk("grant_idx", grant_idx, m_owner);
    chk("timeout", timeout, m_tout);
    chk("m_tvalid", m_tvalid, exp_mv);
    chk("s_tready", s_tready, exp_rdy);
    if (!exp_gv) begin
      chk("m_tdata_idle", m_tdata, 0);
      chk("m_tlast_idle", m_tlast, 0);
    end
    if (exp_mv && m_tready) begin
      if (exp_q[m_owner].size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h on port %0d expected none at %0t",
                 m_tdata, m_owner, $time);
      end else begin
        e = exp_q[m_owner].pop_front();
        chk("beat_data", m_tdata, e.data);
        chk("beat_last", m_tlast, e.last);
      end
    end
    if (grant_valid && !gv_prev) grant_log.push_back(int'(grant_idx));
    gv_prev = grant_valid;
    if (timeout) n_to++;
    for (int p = 0; p < NP; p++) acc[p] = s_tvalid[p] && s_tready[p];
    if (!arst) begin
      if (m_owner < 0) begin
        m_tout = 0;
        found  = 0;
        for (int k = 1; k <= NP; k++) begin
          c = (m_last + k) % NP;
          if (!found && s_tvalid[c]) begin
            found   = 1;
            m_owner = c;
            m_last  = c;
            m_stall = 0;
          end
        end
      end else begin
        m_tout = 0;
        if (s_tvalid[m_owner] && m_tready) begin
          m_stall = 0;
          if (s_tlast[m_owner]) m_owner = -1;
        end else if (!s_tvalid[m_owner]) begin
          m_stall++;
          if (m_stall == TO) begin
            m_owner = -1;
            m_tout  = 1;
          end
        end
      end
    end
  end

  // Issue a beat: it goes to the source and, as the expected output, to the scoreboard.
  task automatic send(int p, logic [DW-1:0] data, logic last, int hold);
    beat_t b;
    b.data = data;
    b.last = last;
    b.hold = hold;
    src_q[p].push_back(b);
    exp_q[p].push_back(b);
  endtask

  // One clock of source behaviour, driven 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (cur_act[p] && acc[p]) cur_act[p] = 0;
      if (!cur_act[p] && src_q[p].size() > 0) begin
        cur[p]      = src_q[p].pop_front();
        cur_hold[p] = cur[p].hold;
        cur_act[p]  = 1;
      end
      if (cur_act[p] && cur_hold[p] == 0) begin
        s_tvalid[p]          = 1'b1;
        s_tlast[p]           = cur[p].last;
        s_tdata[p*DW +: DW]  = cur[p].data;
      end else begin
        s_tvalid[p]          = 1'b0;
        s_tlast[p]           = 1'b0;
        s_tdata[p*DW +: DW]  = DW'($urandom);
        if (cur_act[p]) cur_hold[p]--;
      end
    end
    if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
    else if (rdy_rand)      m_tready = ($urandom_range(3) != 0);
    else                    m_tready = 1'b1;
  endtask

  function automatic bit busy();
    bit b = grant_valid;
    for (int p = 0; p < NP; p++)
      if (src_q[p].size() > 0 || exp_q[p].size() > 0 || cur_act[p]) b = 1;
    return b;
  endfunction

  task automatic drain(int maxc);
    int c = 0;
    while (busy() && c < maxc) begin
      step();
      c++;
    end
    if (c >= maxc) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: still busy after %0d cycles, required idle", maxc);
    end
    repeat (3) step();
  endtask

  // Asynchronous reset mid-cycle; outputs must collapse before the next edge.
  task automatic do_reset();
    #2 arst = 1'b1;
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      cur_act[p] = 0;
    end
    s_tvalid = '0;
    s_tlast  = '0;
    rdy_pat.delete();
    step();
    step();
    arst = 1'b0;
  endtask

  initial begin
    int len, p;
    n_vec = 0; n_err = 0; n_to = 0; gv_prev = 0; rdy_rand = 0;
    arst = 1'b1;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    for (int i = 0; i < NP; i++) begin
      cur_act[i] = 0; acc[i] = 0; cur_hold[i] = 0;
    end
    model_reset();
    repeat (3) step();
    arst = 1'b0;

    // Single source, three bytes.
    grant_log.delete();
    send(0, 8'h41, 0, 0);
    send(0, 8'h42, 0, 0);
    send(0, 8'h43, 1, 0);
    drain(100);
    chk("single_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("single_idx", grant_log[0], 0);

    // Contention from reset: order 0,1,0,1 with no interleaving.
    do_reset();
    grant_log.delete();
    send(0, 8'hA0, 0, 0); send(0, 8'hA1, 1, 0);
    send(1, 8'hB0, 0, 0); send(1, 8'hB1, 1, 0);
    send(0, 8'hC0, 0, 0); send(0, 8'hC1, 1, 0);
    send(1, 8'hD0, 0, 0); send(1, 8'hD1, 1, 0);
    drain(200);
    chk("rr_grants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % 2);

    // Backpressure on port 1 including ten not-ready cycles: no timeout.
    n_to = 0;
    rdy_pat = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 4; i++) send(1, DW'(8'h60 + i), i == 3, 0);
    drain(200);
    chk("bp_no_timeout", n_to, 0);

    // Watchdog: port 0 stalls after one beat, port 1 waits.
    n_to = 0;
    grant_log.delete();
    send(0, 8'h10, 0, 0);
    send(0, 8'h11, 1, 8);
    send(1, 8'h20, 1, 2);
    drain(200);
    chk("wd_pulses", n_to, 1);
    chk("wd_grants", grant_log.size(), 3);
    if (grant_log.size() > 1) chk("wd_next_port", grant_log[1], 1);

    // Reset during beat 2 of 5 on port 0, then port 0 must win first.
    for (int i = 0; i < 5; i++) send(0, DW'(8'h70 + i), i == 4, 0);
    send(1, 8'h7F, 1, 0);
    len = 0;
    while (exp_q[0].size() > 4 && len < 50) begin
      step();
      len++;
    end
    chk("pre_rst_valid", m_tvalid, 1);
    do_reset();
    grant_log.delete();
    send(1, 8'h81, 1, 0);
    send(0, 8'h80, 1, 0);
    drain(100);
    chk("post_rst_grants", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      chk("post_rst_first", grant_log[0], 0);
      chk("post_rst_second", grant_log[1], 1);
    end

    // Back-to-back single-beat packets on port 1.
    grant_log.delete();
    for (int i = 0; i < 3; i++) send(1, DW'(8'h90 + i), 1, 0);
    drain(100);
    chk("sb_grants", grant_log.size(), 3);
    foreach (grant_log[i]) chk("sb_idx", grant_log[i], 1);

    // Randomised traffic with random holds and random ready.
    rdy_rand = 1;
    for (int i = 0; i < 80; i++) begin
      p   = $urandom_range(NP - 1);
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++)
        send(p, DW'($urandom), j == len - 1,
             ($urandom_range(7) == 0) ? $urandom_range(1, 7) : 0);
    end
    drain(20000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
